serial_add: RTL and testbench
=============================

SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits; legal range 1..64.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port start, input, 1: request to begin an operation; sampled on clk.
REQ-006 Port sub, input, 1: 0 = add, 1 = subtract; sampled with start.
REQ-007 Port a, input, WIDTH: first operand; sampled with start.
REQ-008 Port b, input, WIDTH: second operand; sampled with start.
REQ-009 Port cin, input, 1: carry-in for add; ignored when sub=1; sampled with start.
REQ-010 Port busy, output, 1: high while an operation is in progress.
REQ-011 Port done, output, 1: one-cycle pulse marking a valid result.
REQ-012 Port sum, output, WIDTH: result.
REQ-013 Port cout, output, 1: carry-out for add; not-borrow for subtract.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 at a clock edge SHALL latch a, b and the effective carry, clear the bit counter, and enter RUN.
REQ-016 The effective operand SHALL be b when sub=0 and ~b when sub=1.
REQ-017 The effective carry SHALL be cin when sub=0 and 1 when sub=1.
REQ-018 Each RUN cycle SHALL process one bit, LSB first, through one full-adder step.
REQ-019 Each RUN step SHALL shift the result bit into a sum register, update the carry register, and increment the counter.
REQ-020 After exactly WIDTH RUN cycles the FSM SHALL enter DONE, with sum and cout final.
REQ-021 done SHALL be high only in the cycle following the last RUN edge; the latency from the start edge to done=1 SHALL be WIDTH clocks.
REQ-022 busy SHALL be 1 exactly in RUN.
REQ-023 In DONE with start=0 the FSM SHALL return to IDLE on the next edge.
REQ-024 sum and cout SHALL hold their value from done until the next accepted start, including through IDLE.
REQ-025 start during RUN SHALL be ignored: no relatch, no restart, no error.
REQ-026 start in DONE SHALL be accepted (back-to-back); the done pulse SHALL still occur for the finished result.
REQ-027 Input changes on a, b, sub and cin outside the start edge SHALL have no effect.
REQ-028 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap within an operation.
REQ-029 For WIDTH=1, an operation SHALL take one RUN cycle.
REQ-030 The result SHALL be {cout,sum} = a + eff_b + eff_cin, modulo 2^(WIDTH+1).

Reset
REQ-031 While rst_n=0: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, and all operand and carry registers=0.
REQ-032 Assertion of rst_n mid-RUN SHALL abort the operation immediately with no done pulse.
REQ-033 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-034 A shared package serial_add_pkg SHALL hold the state enum (IDLE/RUN/DONE) and a CNT_W function/constant derived from WIDTH.
REQ-035 The one-bit step SHALL be a sub-module fa: inputs a, b, ci; output {co,s}; purely combinational.
REQ-036 fa SHALL be instantiated once; serial_add SHALL hold all registers.

Verification (WIDTH=8 unless stated)
REQ-037 Add overflow: start, a=8'hFF, b=8'h01, cin=0, sub=0 -> busy for 8 cycles, done 8 clocks after the start edge, sum=8'h00, cout=1.
REQ-038 Subtract with borrow: a=8'h05, b=8'h07, sub=1, cin=1 (ignored) -> sum=8'hFE, cout=0; then a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
REQ-039 Start during RUN: start a=8'h10, b=8'h20; at RUN cycle 3 pulse start with a=8'hAA -> single done, sum=8'h30, cout=0.
REQ-040 Back-to-back: start held high through DONE with a=8'h01, b=8'h01 then a=8'h80, b=8'h80 -> done pulses 9 clocks apart; sums 8'h02/cout=0 and 8'h00/cout=1.
REQ-041 Reset mid-RUN: drop rst_n at RUN cycle 4 -> all outputs 0 asynchronously; no done; the next start completes normally.
REQ-042 WIDTH=1 exhaustive: all 8 combinations of a, b, cin with sub=0 -> {cout,sum} equals the full-adder truth table; latency 1 clock each.

Source files
------------

// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//   Shared definitions for the bit-serial adder/subtractor.
//   - state_t   : controller states (IDLE, RUN, DONE)
//   - cnt_w()   : width of the bit counter for a given operand width
//   - eff_carry : carry injected into bit 0 for add/subtract
// ---------------------------------------------------------------------------
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must be able to hold the value WIDTH itself so it never
  // wraps inside an operation, hence WIDTH+1 distinct values.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Subtraction is a + ~b + 1, so the carry-in is forced to 1 and the
  // external cin only matters for addition.
  function automatic logic eff_carry(input logic sub, input logic cin);
    return sub ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/serial_add_fa.sv
// ---------------------------------------------------------------------------
// fa
//   One-bit full adder, purely combinational. This is the single arithmetic
//   element of the serial adder; it is reused once per RUN cycle.
//   Ports:
//     a, b : operand bits
//     ci   : carry in
//     s    : sum bit
//     co   : carry out
// ---------------------------------------------------------------------------
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  // Generate when both bits are set, propagate an incoming carry otherwise.
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_add.sv
// ---------------------------------------------------------------------------
// serial_add
//   Bit-serial adder/subtractor. On an accepted start the operands are
//   latched and processed one bit per clock, LSB first, through a single
//   full adder. The result appears WIDTH clocks after the start edge and is
//   held until the next accepted start.
//
//   Parameters:
//     WIDTH : operand width in bits (1..64)
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     start : begin an operation (accepted in IDLE or DONE, ignored in RUN)
//     sub   : 0 = add, 1 = subtract (sampled with start)
//     a, b  : operands (sampled with start)
//     cin   : carry-in for add, ignored for subtract (sampled with start)
//     busy  : high while the operation is running
//     done  : one-cycle pulse when sum/cout become valid
//     sum   : result
//     cout  : carry-out for add, not-borrow for subtract
// ---------------------------------------------------------------------------
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_w(WIDTH);
  // Counter value seen during the final RUN step.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             step_s;
  logic             step_co;
  logic [WIDTH-1:0] sum_next;

  // The operand registers shift right every RUN cycle, so bit 0 is always
  // the bit currently being added.
  fa u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .ci (carry),
    .s  (step_s),
    .co (step_co)
  );

  // New result bit enters at the MSB; after WIDTH shifts the first bit
  // computed has reached the LSB. Written as a shift plus a bit write so it
  // stays legal when WIDTH is 1.
  always_comb begin
    sum_next            = sum_reg >> 1;
    sum_next[WIDTH-1]   = step_s;
  end

  // Controller and datapath registers. busy/done are registered alongside
  // the state so they are glitch-free and line up with the state they mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        // A finished result can be followed immediately by a new start;
        // the done pulse for that result is already on the output.
        IDLE, DONE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= sub ? ~b : b;
            carry    <= eff_carry(sub, cin);
            cnt      <= '0;
            state    <= RUN;
            busy_reg <= 1'b1;
          end else begin
            state    <= IDLE;
            busy_reg <= 1'b0;
          end
        end

        // start is deliberately not looked at here.
        RUN: begin
          sum_reg <= sum_next;
          carry   <= step_co;
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            cout_reg <= step_co;
            state    <= DONE;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add.sv
// ---------------------------------------------------------------------------
// tb_serial_add
//   Self-checking bench for serial_add: a WIDTH=8 instance exercised with a
//   vector table, random operations against an arithmetic model, and the
//   multi-cycle corner cases; plus a WIDTH=1 instance checked exhaustively.
// ---------------------------------------------------------------------------
module tb_serial_add;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start1 = 1'b0;
  logic       sub1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] esum;
    logic       ecout;
  } vec_t;

  vec_t vecs[8];

  serial_add #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  // Reference: {cout,sum} = a + effective b + effective carry, 9 bits.
  function automatic logic [8:0] model(input logic s, input logic [7:0] av,
                                       input logic [7:0] bv, input logic c);
    logic [8:0] eb;
    logic [8:0] ec;
    eb = s ? {1'b0, ~bv} : {1'b0, bv};
    ec = s ? 9'd1 : {8'd0, c};
    return {1'b0, av} + eb + ec;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Presents one operation at a negedge, lets the start edge pass, then
  // scrambles the inputs so any late sampling would corrupt the result.
  task automatic applyStimulus(input logic s, input logic [7:0] av,
                               input logic [7:0] bv, input logic c);
    @(negedge clk);
    sub = s; a = av; b = bv; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    sub = 1'($urandom); cin = 1'($urandom);
  endtask

  task automatic runAndCheck(input string name, input logic s,
                             input logic [7:0] av, input logic [7:0] bv,
                             input logic c, input logic [7:0] es,
                             input logic ec);
    int lat;
    int busyCnt;
    lat = 0;
    busyCnt = 0;
    applyStimulus(s, av, bv, c);
    if (busy) busyCnt++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busyCnt++;
    end
    checkOutput({name, ".latency"}, lat, 8);
    checkOutput({name, ".busycycles"}, busyCnt, 8);
    checkOutput({name, ".sum"}, sum, es);
    checkOutput({name, ".cout"}, cout, ec);
    @(posedge clk);
    #1;
    checkOutput({name, ".donepulse"}, done, 0);
    checkOutput({name, ".busyidle"}, busy, 0);
    checkOutput({name, ".sumhold"}, sum, es);
    checkOutput({name, ".couthold"}, cout, ec);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int lat2;
    int doneCnt;
    logic [7:0] s1, s2;
    logic c1, c2;
    logic [8:0] exp;
    logic [7:0] ra, rb;
    logic rs, rc;

    vecs[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0};
    vecs[2] = '{1'b1, 8'h07, 8'h05, 1'b0, 8'h02, 1'b1};
    vecs[3] = '{1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vecs[4] = '{1'b0, 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};
    vecs[5] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    // Reset state
    #12;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.sum", sum, 0);
    checkOutput("reset.cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b,
                  vecs[i].cin, vecs[i].esum, vecs[i].ecout);
    end

    // Random operations against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      exp = model(rs, ra, rb, rc);
      runAndCheck($sformatf("rand%0d", i), rs, ra, rb, rc, exp[7:0], exp[8]);
    end

    // Start during RUN is ignored
    applyStimulus(1'b0, 8'h10, 8'h20, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'hAA;
    @(posedge clk);
    #1;
    start = 1'b0;
    doneCnt = 0; lat = 0; s1 = '0; c1 = 1'b0;
    for (int k = 4; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        doneCnt++;
        if (lat == 0) begin
          lat = k; s1 = sum; c1 = cout;
        end
      end
    end
    checkOutput("ignore.donecount", doneCnt, 1);
    checkOutput("ignore.latency", lat, 8);
    checkOutput("ignore.sum", s1, 8'h30);
    checkOutput("ignore.cout", c1, 0);

    // Back-to-back with start held through DONE
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h01; b = 8'h01; cin = 1'b0;
    @(posedge clk);
    #1;
    a = 8'h80; b = 8'h80;
    doneCnt = 0; lat = 0; lat2 = 0;
    s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        doneCnt++;
        if (doneCnt == 1) begin lat = k; s1 = sum; c1 = cout; end
        else begin lat2 = k; s2 = sum; c2 = cout; end
      end
      if (k == 9) start = 1'b0;
      if (doneCnt == 2) break;
    end
    checkOutput("b2b.first_time", lat, 8);
    checkOutput("b2b.second_time", lat2, 17);
    checkOutput("b2b.sum1", s1, 8'h02);
    checkOutput("b2b.cout1", c1, 0);
    checkOutput("b2b.sum2", s2, 8'h00);
    checkOutput("b2b.cout2", c2, 1);

    // Reset in the middle of RUN
    repeat (2) @(posedge clk);
    applyStimulus(1'b0, 8'h3C, 8'h5A, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.done", done, 0);
    checkOutput("abort.sum", sum, 0);
    checkOutput("abort.cout", cout, 0);
    @(posedge clk);
    #1;
    checkOutput("abort.done_held", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; sub = 1'b0; a = 8'h3C; b = 8'h5A; cin = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("restart.busy_first_edge", busy, 1);
    doneCnt = 0; lat = 0; s1 = '0; c1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        doneCnt++;
        if (lat == 0) begin lat = k; s1 = sum; c1 = cout; end
      end
    end
    checkOutput("restart.donecount", doneCnt, 1);
    checkOutput("restart.latency", lat, 8);
    checkOutput("restart.sum", s1, 8'h97);
    checkOutput("restart.cout", c1, 0);

    // WIDTH=1 exhaustive full-adder table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] e;
      v = 3'(i);
      e = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; sub1 = 1'b0; start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      checkOutput($sformatf("w1_%0d.busy", i), busy1, 1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("w1_%0d.done", i), done1, 1);
      checkOutput($sformatf("w1_%0d.result", i), {cout1, sum1}, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
